card_auth: RTL and testbench

Card-payment front end that sits directly upstream of the vending controller. It debounces the physical card-detect line and latches the card balance. It issues the single-cycle `CARD_IN` that starts a vending session, and answers the controller's `COST` request with either a `VALID_TRAN` pulse (debiting the balance) or a decline. The card is ejected at session end.

---
 rtl/card_auth_if.sv | 24 ++
 rtl/card_auth.sv | 158 +++++++++++++++
 tb/tb_card_auth.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_auth_if.sv
// Signal bundle between the card reader / vending controller and card_auth.
// The slave view belongs to card_auth; the master view drives it.
interface card_auth_if;
  logic       CARD_INSERT;
  logic [7:0] CARD_BALANCE;
  logic [2:0] COST;
  logic       VEND;
  logic       FAILED_TRAN;
  logic       CARD_IN;
  logic       VALID_TRAN;
  logic       DECLINED;
  logic       CARD_EJECT;
  logic [7:0] BALANCE;

  modport master (
    output CARD_INSERT, CARD_BALANCE, COST, VEND, FAILED_TRAN,
    input  CARD_IN, VALID_TRAN, DECLINED, CARD_EJECT, BALANCE
  );

  modport slave (
    input  CARD_INSERT, CARD_BALANCE, COST, VEND, FAILED_TRAN,
    output CARD_IN, VALID_TRAN, DECLINED, CARD_EJECT, BALANCE
  );
endinterface

// File: rtl/card_auth.sv
// Card-payment front end: debounces card insertion, latches the balance and
// authorises one debit per insertion before ejecting the card.
module card_auth #(
  parameter int DEBOUNCE     = 3,
  parameter int AUTH_LATENCY = 2,
  parameter int ARM_TIMEOUT  = 12
) (
  input logic        CLK,
  input logic        RESET,
  card_auth_if.slave auth_bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_ARMED,
    ST_AUTH,
    ST_GRANT,
    ST_WAIT_DONE,
    ST_EJECT
  } state_t;

  // Terminal counts: ARMED and AUTH each last exactly their parameter in cycles.
  localparam logic [3:0] DEB_TERM = 4'(DEBOUNCE);
  localparam logic [3:0] ARM_TERM = 4'(ARM_TIMEOUT - 1);
  localparam logic [1:0] LAT_TERM = 2'(AUTH_LATENCY - 1);

  state_t     state, state_d;
  logic [3:0] deb_cnt, deb_cnt_d;
  logic [3:0] arm_cnt, arm_cnt_d;
  logic [1:0] lat_cnt, lat_cnt_d;
  logic [2:0] cost_q, cost_d;
  logic [7:0] balance_q, balance_d;
  logic       vend_seen, vend_seen_d;
  logic       card_in_q, card_in_d;
  logic       valid_q, valid_d;
  logic       declined_q, declined_d;
  logic       eject_q, eject_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      deb_cnt    <= '0;
      arm_cnt    <= '0;
      lat_cnt    <= '0;
      cost_q     <= '0;
      balance_q  <= '0;
      vend_seen  <= 1'b0;
      card_in_q  <= 1'b0;
      valid_q    <= 1'b0;
      declined_q <= 1'b0;
      eject_q    <= 1'b0;
    end else begin
      state      <= state_d;
      deb_cnt    <= deb_cnt_d;
      arm_cnt    <= arm_cnt_d;
      lat_cnt    <= lat_cnt_d;
      cost_q     <= cost_d;
      balance_q  <= balance_d;
      vend_seen  <= vend_seen_d;
      card_in_q  <= card_in_d;
      valid_q    <= valid_d;
      declined_q <= declined_d;
      eject_q    <= eject_d;
    end
  end

  always_comb begin
    state_d     = state;
    deb_cnt_d   = deb_cnt;
    arm_cnt_d   = arm_cnt;
    lat_cnt_d   = lat_cnt;
    cost_d      = cost_q;
    balance_d   = balance_q;
    vend_seen_d = vend_seen | auth_bus.VEND;
    card_in_d   = 1'b0;
    valid_d     = 1'b0;
    declined_d  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (auth_bus.CARD_INSERT) begin
          state_d   = ST_DEBOUNCE;
          deb_cnt_d = 4'd1;
        end
      end
      ST_DEBOUNCE: begin
        if (!auth_bus.CARD_INSERT) begin
          state_d   = ST_IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt == DEB_TERM) begin
          state_d     = ST_ARMED;
          deb_cnt_d   = '0;
          arm_cnt_d   = '0;
          vend_seen_d = 1'b0;
          balance_d   = auth_bus.CARD_BALANCE;
          card_in_d   = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt + 4'd1;
        end
      end
      // A failure outranks a cost request, and a cost request outranks the timeout.
      ST_ARMED: begin
        if (!auth_bus.CARD_INSERT || auth_bus.FAILED_TRAN) begin
          state_d = ST_EJECT;
        end else if (auth_bus.COST != 3'd0) begin
          state_d   = ST_AUTH;
          cost_d    = auth_bus.COST;
          lat_cnt_d = '0;
        end else if (arm_cnt == ARM_TERM) begin
          state_d = ST_EJECT;
        end else begin
          arm_cnt_d = arm_cnt + 4'd1;
        end
      end
      ST_AUTH: begin
        if (!auth_bus.CARD_INSERT || auth_bus.FAILED_TRAN) begin
          state_d = ST_EJECT;
        end else if (lat_cnt == LAT_TERM) begin
          if (balance_q >= {5'd0, cost_q}) begin
            state_d   = ST_GRANT;
            balance_d = balance_q - {5'd0, cost_q};
          end else begin
            state_d    = ST_EJECT;
            declined_d = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt + 2'd1;
        end
      end
      ST_GRANT: begin
        state_d = ST_WAIT_DONE;
        valid_d = 1'b1;
      end
      ST_WAIT_DONE: begin
        if (!auth_bus.CARD_INSERT || auth_bus.COST == 3'd0) begin
          state_d = ST_EJECT;
        end
      end
      ST_EJECT: begin
        if (!auth_bus.CARD_INSERT) begin
          state_d   = ST_IDLE;
          balance_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    eject_d = (state_d == ST_EJECT);
  end

  assign auth_bus.CARD_IN    = card_in_q;
  assign auth_bus.VALID_TRAN = valid_q;
  assign auth_bus.DECLINED   = declined_q;
  assign auth_bus.CARD_EJECT = eject_q;
  assign auth_bus.BALANCE    = balance_q;

endmodule

// File: tb/tb_card_auth.sv
// Randomised sessions against a cycle-arithmetic model of card_auth; expected
// output events are queued by the stimulus and checked by a negedge monitor.
module tb_card_auth;

  localparam int DEB = 3;
  localparam int LAT = 2;
  localparam int TMO = 12;

  typedef struct {
    int t;
    bit ci;
    bit vt;
    bit dc;
    bit er;
    bit ef;
    int bal;
  } obs_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  obs_t exp_q[$];

  card_auth_if bus ();

  card_auth #(
    .DEBOUNCE    (DEB),
    .AUTH_LATENCY(LAT),
    .ARM_TIMEOUT (TMO)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .auth_bus(bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every cycle with a pulse or a CARD_EJECT edge consumes one expectation.
  logic prev_eject = 1'b0;
  bit   mon_er, mon_ef;
  obs_t mon_exp;

  always @(negedge CLK) begin
    mon_er = bus.CARD_EJECT && !prev_eject;
    mon_ef = !bus.CARD_EJECT && prev_eject;
    prev_eject = bus.CARD_EJECT;
    if (!RESET && (bus.CARD_IN || bus.VALID_TRAN || bus.DECLINED || mon_er || mon_ef)) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_event actual cyc=%0d ci=%0b vt=%0b dc=%0b er=%0b ef=%0b required=no event",
                 cyc, bus.CARD_IN, bus.VALID_TRAN, bus.DECLINED, mon_er, mon_ef);
      end else begin
        mon_exp = exp_q.pop_front();
        if (cyc != mon_exp.t || bus.CARD_IN != mon_exp.ci || bus.VALID_TRAN != mon_exp.vt ||
            bus.DECLINED != mon_exp.dc || mon_er != mon_exp.er || mon_ef != mon_exp.ef) begin
          fails++;
          $display("[TB] FAIL event actual cyc=%0d ci=%0b vt=%0b dc=%0b er=%0b ef=%0b required cyc=%0d ci=%0b vt=%0b dc=%0b er=%0b ef=%0b",
                   cyc, bus.CARD_IN, bus.VALID_TRAN, bus.DECLINED, mon_er, mon_ef,
                   mon_exp.t, mon_exp.ci, mon_exp.vt, mon_exp.dc, mon_exp.er, mon_exp.ef);
        end
        checks++;
        if (int'(bus.BALANCE) != mon_exp.bal) begin
          fails++;
          $display("[TB] FAIL event_balance cyc=%0d actual=%0d required=%0d", cyc, bus.BALANCE, mon_exp.bal);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic expect_obs(input int t, input bit ci, input bit vt, input bit dc,
                            input bit er, input bit ef, input int bal);
    obs_t o;
    o.t = t; o.ci = ci; o.vt = vt; o.dc = dc; o.er = er; o.ef = ef; o.bal = bal;
    exp_q.push_back(o);
  endtask

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Card is being ejected: pulling it clears the balance on the next edge.
  task automatic remove_card();
    int x;
    bus.CARD_INSERT = 1'b0;
    x = cyc;
    expect_obs(x + 1, 0, 0, 0, 0, 1, 0);
    wait_until(x + 1);
  endtask

  // scen: 0 timeout, 1 failure in ARMED (with COST=c alongside), 2 removal in ARMED,
  // 3 purchase attempt, 4 abort during AUTH. k = highs before a bounce low.
  task automatic applyStimulus(input int scen, input int b, input int c, input int d, input int k);
    int r, tin, a, w, s, j;
    if (k > 0) begin
      bus.CARD_INSERT = 1'b1;
      bus.CARD_BALANCE = 8'($urandom);
      repeat (k) tick();
      bus.CARD_INSERT = 1'b0;
      tick();
    end
    bus.CARD_INSERT = 1'b1;
    bus.CARD_BALANCE = 8'(b);
    r = cyc;
    tin = r + DEB + 1;
    expect_obs(tin, 1, 0, 0, 0, 0, b);
    wait_until(tin);
    bus.CARD_BALANCE = 8'($urandom);
    if (scen == 0) begin
      expect_obs(tin + TMO, 0, 0, 0, 1, 0, b);
      wait_until(tin + TMO);
      remove_card();
    end else begin
      repeat (d) tick();
      a = cyc;
      case (scen)
        1: begin
          bus.FAILED_TRAN = 1'b1;
          bus.COST = 3'(c);
          expect_obs(a + 1, 0, 0, 0, 1, 0, b);
          tick();
          bus.FAILED_TRAN = 1'b0;
          bus.COST = 3'd0;
          remove_card();
        end
        2: begin
          bus.CARD_INSERT = 1'b0;
          expect_obs(a + 1, 0, 0, 0, 1, 0, b);
          expect_obs(a + 2, 0, 0, 0, 0, 1, 0);
          wait_until(a + 2);
        end
        3: begin
          bus.COST = 3'(c);
          if (b >= c) expect_obs(a + 2 + LAT, 0, 1, 0, 0, 0, b - c);
          else        expect_obs(a + 1 + LAT, 0, 0, 1, 1, 0, b);
          tick();
          if ($urandom_range(0, 1) == 1) bus.COST = 3'($urandom_range(1, 7));
          if (b >= c) begin
            wait_until(a + 2 + LAT);
            repeat ($urandom_range(0, 3)) begin
              bus.VEND = 1'($urandom_range(0, 1));
              bus.FAILED_TRAN = 1'($urandom_range(0, 1));
              tick();
            end
            bus.VEND = 1'b0;
            bus.FAILED_TRAN = 1'b0;
            w = cyc;
            if ($urandom_range(0, 1) == 1) begin
              bus.COST = 3'd0;
              expect_obs(w + 1, 0, 0, 0, 1, 0, b - c);
              wait_until(w + 1);
              remove_card();
            end else begin
              bus.CARD_INSERT = 1'b0;
              expect_obs(w + 1, 0, 0, 0, 1, 0, b - c);
              expect_obs(w + 2, 0, 0, 0, 0, 1, 0);
              wait_until(w + 2);
            end
          end else begin
            wait_until(a + 1 + LAT);
            bus.COST = 3'd0;
            remove_card();
          end
        end
        default: begin
          bus.COST = 3'(c);
          tick();
          j = $urandom_range(0, LAT - 1);
          repeat (j) tick();
          s = cyc;
          if ($urandom_range(0, 1) == 1) begin
            bus.CARD_INSERT = 1'b0;
            expect_obs(s + 1, 0, 0, 0, 1, 0, b);
            expect_obs(s + 2, 0, 0, 0, 0, 1, 0);
            wait_until(s + 2);
          end else begin
            bus.FAILED_TRAN = 1'b1;
            expect_obs(s + 1, 0, 0, 0, 1, 0, b);
            wait_until(s + 1);
            bus.FAILED_TRAN = 1'b0;
            remove_card();
          end
        end
      endcase
    end
    bus.COST = 3'd0;
    bus.VEND = 1'b0;
    bus.FAILED_TRAN = 1'b0;
    repeat ($urandom_range(1, 3)) tick();
  endtask

  task automatic reset_in_auth();
    int tin;
    bus.CARD_INSERT = 1'b1;
    bus.CARD_BALANCE = 8'd50;
    tin = cyc + DEB + 1;
    expect_obs(tin, 1, 0, 0, 0, 0, 50);
    wait_until(tin);
    bus.COST = 3'd2;
    tick();
    RESET = 1'b1;
    tick();
    checkOutput("rst_auth_card_in", int'(bus.CARD_IN), 0);
    checkOutput("rst_auth_valid", int'(bus.VALID_TRAN), 0);
    checkOutput("rst_auth_declined", int'(bus.DECLINED), 0);
    checkOutput("rst_auth_eject", int'(bus.CARD_EJECT), 0);
    checkOutput("rst_auth_balance", int'(bus.BALANCE), 0);
    RESET = 1'b0;
    bus.CARD_INSERT = 1'b0;
    bus.COST = 3'd0;
    repeat (2) tick();
  endtask

  initial begin
    int scen, b, c;
    bus.CARD_INSERT = 1'b0;
    bus.CARD_BALANCE = 8'd0;
    bus.COST = 3'd0;
    bus.VEND = 1'b0;
    bus.FAILED_TRAN = 1'b0;
    RESET = 1'b1;
    repeat (3) tick();
    checkOutput("reset_card_in", int'(bus.CARD_IN), 0);
    checkOutput("reset_valid", int'(bus.VALID_TRAN), 0);
    checkOutput("reset_declined", int'(bus.DECLINED), 0);
    checkOutput("reset_eject", int'(bus.CARD_EJECT), 0);
    checkOutput("reset_balance", int'(bus.BALANCE), 0);
    RESET = 1'b0;
    tick();

    applyStimulus(3, 20, 5, 3, 0);
    applyStimulus(3, 3, 6, 1, 0);
    applyStimulus(3, 4, 4, 0, 0);
    applyStimulus(4, 30, 2, 2, 2);
    applyStimulus(0, 77, 0, 0, 0);
    applyStimulus(1, 40, 2, 1, 0);
    applyStimulus(2, 11, 0, 5, 1);
    applyStimulus(3, 9, 1, TMO - 1, 0);
    applyStimulus(3, 255, 7, 0, DEB);
    reset_in_auth();

    for (int i = 0; i < 60; i++) begin
      scen = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 8);
      else                           b = $urandom_range(0, 255);
      c = (scen == 1) ? $urandom_range(0, 7) : $urandom_range(1, 7);
      applyStimulus(scen, b, c, $urandom_range(0, TMO - 1), $urandom_range(0, DEB));
    end

    repeat (4) tick();
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
